// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the MIPS multiply/divide unit and the CPU decoder.
// Holds the operation encoding, the state constants and the MIPS function codes.
// Optional fast multiply is selected in the unit itself by MIPS_MULDIV_FAST_MULT_EN.
package mips_muldiv_pkg;

  // Operation issued by EXEC; encodings 6 and 7 are undefined and ignored.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  // Sequencer state, kept as plain constants so older code can compare raw bits.
  typedef logic [1:0] muldiv_state_t;
  localparam muldiv_state_t ST_IDLE = 2'd0;
  localparam muldiv_state_t ST_MUL  = 2'd1;
  localparam muldiv_state_t ST_DIV  = 2'd2;
  localparam muldiv_state_t ST_FIX  = 2'd3;

  // MIPS SPECIAL function codes, shared with the CPU instruction decoder.
  localparam logic [5:0] FUNCT_MTHI  = 6'd17;
  localparam logic [5:0] FUNCT_MTLO  = 6'd19;
  localparam logic [5:0] FUNCT_MULT  = 6'd24;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_DIV   = 6'd26;
  localparam logic [5:0] FUNCT_DIVU  = 6'd27;

  // Signed operations take magnitudes at issue and fix the sign afterwards.
  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mips_muldiv_signfix.sv
// Conditional two's-complement negate: magnitude at issue, sign restore in FIX.
// Purely combinational, zero latency.
// No handshake; the result follows the inputs.
module mips_muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  // Negating the most-negative value returns it unchanged, which is exactly
  // the magnitude the unsigned datapath needs for that operand.
  assign res = neg ? (~val + {{(W-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO, owning the HI/LO registers.
// Latency: done in T+WIDTH+2 after issue in T (T+3 for multiply with MIPS_MULDIV_FAST_MULT_EN).
// No queueing: start is only sampled in IDLE, so issues while busy are dropped.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  muldiv_state_t    state;
  logic [CNT_W-1:0] cnt;
  // acc_hi: product upper half / partial remainder.
  // acc_lo: multiplier being shifted out / dividend shifting into quotient.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;       // multiplicand or divisor magnitude
  logic             sign_a;
  logic             sign_b;
  logic             div_op;
  logic             div_zero;

  logic             issue_signed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign issue_signed = op_is_signed(op);
  assign busy         = (state != ST_IDLE);

  mips_muldiv_signfix #(.W(WIDTH)) u_mag_a (
    .val (rs_val),
    .neg (issue_signed & rs_val[WIDTH-1]),
    .res (mag_a)
  );

  mips_muldiv_signfix #(.W(WIDTH)) u_mag_b (
    .val (rt_val),
    .neg (issue_signed & rt_val[WIDTH-1]),
    .res (mag_b)
  );

  // Restoring division step: shift the next dividend bit into the remainder
  // and subtract the divisor when it fits. The remainder always stays below
  // the divisor, so the difference fits in WIDTH bits.
  logic [WIDTH:0]   div_shift;
  logic             div_fits;
  logic [WIDTH-1:0] div_diff;

  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_fits  = (div_shift >= {1'b0, opnd});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd;

`ifdef MIPS_MULDIV_FAST_MULT_EN
  // Whole magnitude product in one cycle; the sign is still fixed in FIX.
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, acc_lo};
`else
  // Radix-2 shift-add step: conditionally add the multiplicand into the upper
  // half, keeping the carry so it shifts down into the product.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
`endif

  // Sign restoration of the finished magnitude results.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  mips_muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (
    .val ({acc_hi, acc_lo}),
    .neg (sign_a ^ sign_b),
    .res (prod_fix)
  );

  mips_muldiv_signfix #(.W(WIDTH)) u_fix_quot (
    .val (acc_lo),
    .neg (sign_a ^ sign_b),
    .res (quot_fix)
  );

  // With a zero divisor every step "fits", so the remainder ends up holding
  // the dividend magnitude; re-applying the dividend sign yields rs_val.
  mips_muldiv_signfix #(.W(WIDTH)) u_fix_rem (
    .val (acc_hi),
    .neg (sign_a),
    .res (rem_fix)
  );

  // Sequencer, datapath registers and HI/LO update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_op   <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                state    <= ST_MUL;
                cnt      <= CNT_LAST;
                acc_hi   <= '0;
                acc_lo   <= mag_b;
                opnd     <= mag_a;
                sign_a   <= issue_signed & rs_val[WIDTH-1];
                sign_b   <= issue_signed & rt_val[WIDTH-1];
                div_op   <= 1'b0;
                div_zero <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                state    <= ST_DIV;
                cnt      <= CNT_LAST;
                acc_hi   <= '0;
                acc_lo   <= mag_a;
                opnd     <= mag_b;
                sign_a   <= issue_signed & rs_val[WIDTH-1];
                sign_b   <= issue_signed & rt_val[WIDTH-1];
                div_op   <= 1'b1;
                div_zero <= (rt_val == '0);
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
`ifdef MIPS_MULDIV_FAST_MULT_EN
          {acc_hi, acc_lo} <= fast_prod;
          state            <= ST_FIX;
`else
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          if (cnt == '0) state <= ST_FIX;
          else           cnt   <= cnt - CNT_ONE;
`endif
        end
        ST_DIV: begin
          acc_hi <= div_fits ? div_diff : div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_fits};
          if (cnt == '0) state <= ST_FIX;
          else           cnt   <= cnt - CNT_ONE;
        end
        ST_FIX: begin
          if (div_op) begin
            lo <= div_zero ? '1 : quot_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit (WIDTH=32): arithmetic reference model compared every
// cycle, plus directed operations with hand-computed HI/LO and done latency.
// Honours MIPS_MULDIV_FAST_MULT_EN for the expected multiply latency.
`timescale 1ns/1ps
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;

  localparam int W = 32;
`ifdef MIPS_MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = W + 2;
`endif
  localparam int DIV_LAT = W + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  muldiv_op_t op = OP_MTHI;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic       busy;
  logic       done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural result {hi, lo} of an operation, from plain arithmetic.
  function automatic logic [63:0] ref_result(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    case (o)
      OP_MULT:  return longint'(sa) * longint'(sb);
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Reference model: busy countdown, pending result, HI/LO as seen by the CPU.
  int          m_left = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_done = 1'b0;
  logic [63:0] m_pend = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
        end
      end else if (start) begin
        case (op)
          OP_MTHI: m_hi = rs_val;
          OP_MTLO: m_lo = rs_val;
          OP_MULT, OP_MULTU: begin
            m_pend = ref_result(op, rs_val, rt_val);
            m_left = MUL_LAT - 1;
          end
          OP_DIV, OP_DIVU: begin
            m_pend = ref_result(op, rs_val, rt_val);
            m_left = DIV_LAT - 1;
          end
          default: ;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("cyc busy", busy, m_left > 0);
      chk("cyc done", done, m_done);
      chk("cyc hi", hi, m_hi);
      chk("cyc lo", lo, m_lo);
    end
  end

  // Issue one operation, optionally try a MULT while it is busy, and measure
  // edges from the accepting edge until done is seen.
  task automatic run_op(input string name, input muldiv_op_t o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat, input bit inject);
    int n;
    n = 0;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0; rs_val = $urandom; rt_val = $urandom;
      if (inject && n == 5) begin
        start = 1'b1; op = OP_MULT; rs_val = 32'd3; rt_val = 32'd3;
      end
    end while (!done && n < 100);
    start = 1'b0;
    chk({name, " latency"}, n, elat);
    chk({name, " hi"}, hi, ehi);
    chk({name, " lo"}, lo, elo);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    reset = 1'b0;

    // Hand-computed results pin the model as well as the DUT.
    run_op("multu max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, 1'b0);
    run_op("mult -3x7",   OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT, 1'b0);
    run_op("mult minxmin",OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LAT, 1'b0);
    run_op("multu 16x",   OP_MULTU, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780, MUL_LAT, 1'b0);
    run_op("div -7/2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, 1'b0);
    run_op("div 7/-2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT, 1'b0);
    run_op("divu 7/2",    OP_DIVU,  32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, DIV_LAT, 1'b0);
    run_op("div ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT, 1'b0);
    run_op("divu 5/0",    OP_DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, DIV_LAT, 1'b0);
    run_op("div -9/0",    OP_DIV,   32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, DIV_LAT, 1'b0);
    run_op("div busy st", OP_DIV,   32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, DIV_LAT, 1'b1);

    // MTHI/MTLO: visible the next cycle, no busy, no done.
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; rs_val = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    chk("mthi hi", hi, 32'h1234_5678);
    chk("mthi done", done, 1'b0);
    chk("mthi busy", busy, 1'b0);
    start = 1'b1; op = OP_MTLO; rs_val = 32'hCAFE_F00D;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo lo", lo, 32'hCAFE_F00D);
    chk("mtlo hi kept", hi, 32'h1234_5678);

    // Undefined encoding is ignored.
    start = 1'b1; op = muldiv_op_t'(3'd6); rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; op = OP_MTHI;
    chk("undef busy", busy, 1'b0);
    chk("undef hi", hi, 32'h1234_5678);
    chk("undef lo", lo, 32'hCAFE_F00D);

    // Reset during DIV iteration 10 aborts immediately.
    start = 1'b1; op = OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre-rst busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_op("divu after rst", OP_DIVU, 32'd1000, 32'd33, 32'h0000_000A, 32'h0000_001E, DIV_LAT, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
